sram1rw_req_ctrl: RTL and testbench
===================================

# sram1rw_req_ctrl

Request-side controller for one single-port 512x32 SRAM1RW macro in the tech-asap7 cache collateral. Converts a valid/ready read/write request stream into the macro's active-low pin protocol (CSB/WEB/OEB, A, I), captures the registered read data O one cycle after issue, and returns it on a valid/ready response stream through a 3-entry buffer. Sits between cache/scratchpad control logic and each SRAM macro instance; the macro's CE pin is tied to `clock` at the instantiating level.

## Interface
- ADDR_W, 9, word address width (macro depth 2^ADDR_W)
- DATA_W, 32, data width; must be a multiple of 8
- MASK_W, DATA_W/8, byte-mask width (derived; not overridden)

- clock  in  1  block clock; same net drives the macro CE
- reset_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted when valid && ready
- req_write  in  1  1 = write, 0 = read
- req_addr  in  ADDR_W  word address
- req_wdata  in  DATA_W  write data
- req_wmask  in  MASK_W  byte write enables (see Configuration)
- resp_valid  out  1  read data present
- resp_ready  in  1  consumer accepts read data
- resp_rdata  out  DATA_W  read data, head of response buffer
- sram_A  out  ADDR_W  macro address
- sram_CSB  out  1  macro chip select, active low
- sram_WEB  out  1  macro write enable, active low
- sram_OEB  out  1  macro read enable, active low
- sram_I  out  DATA_W  macro write data
- sram_O  in  DATA_W  macro read data (registered inside macro)

## Operation
- Idle pin state: CSB=1, WEB=1, OEB=1, A=0, I=0. At most one macro access per cycle.
- SRAM pins are combinational from the accepted request (or from internal RMW registers) in the issue cycle; macro samples them at the end of that cycle.
- Read: issue CSB=0, OEB=0, WEB=1, A=req_addr. Next cycle sram_O holds data; controller pushes it into the response buffer at that cycle's end.
- Full write: CSB=0, WEB=0, OEB=1, A, I=req_wdata. Writes are posted; no response.
- Read credit: a read is accepted only if (reads in flight, 0..1) + buffer occupancy < 3. Writes ignore credit.
- Response buffer: 3-entry FIFO, in-order; push and pop in the same cycle allowed at any occupancy including full (credit rule guarantees no overflow).
- req_ready = 1 in IDLE unless request is a read and credit is exhausted; 0 in RMW_MERGE.
- FSM (RMW only): IDLE -> RMW_MERGE on accepting a partial-mask write (issues read of req_addr, latches addr/wdata/mask). RMW_MERGE: merged = mask ? wdata : sram_O per byte; issues write of merged; -> IDLE. RMW read does not consume credit and is never pushed to the buffer.
- Mask all-zero write: accepted, no macro access.
- Read-after-write to same address in consecutive cycles returns new data (macro ordering suffices; no forwarding).
- Reset (async, any time): FSM -> IDLE, buffer and in-flight flag cleared, resp_valid=0, req_ready=0 while reset_n=0, SRAM pins idle immediately. In-flight read or pending RMW write is dropped.

## Timing
- Reset values: req_ready=0, resp_valid=0, resp_rdata=0, sram_CSB/WEB/OEB=1, sram_A=0, sram_I=0.
- Read latency: accept in cycle N -> resp_valid earliest in cycle N+2.
- Sustained read throughput 1/cycle with resp_ready held high.
- Partial write occupies 2 cycles (read in N, write in N+1); next request accepted in N+2.
- resp_valid/resp_rdata held stable until resp_ready.

## Configuration
- SRAM1RW_REQ_CTRL_RMW_EN defined: byte masks honoured via the RMW FSM; all-ones mask = single-cycle full write; all-zero = no access.
- Undefined: req_wmask ignored; every write is a single-cycle full-word write; no RMW_MERGE state; req_ready depends only on read credit.

## Test plan
- Write 0xDEADBEEF to addr 5, read addr 5 next cycle -> resp_rdata=0xDEADBEEF at cycle N+2 of read accept.
- Back-to-back reads of addrs 0..15 with resp_ready=1 -> req_ready never drops, 16 responses in order, one per cycle.
- resp_ready=0, issue 5 reads -> exactly 3 accepted, req_ready=0 with req_write=0; writes still accepted; release resp_ready -> remaining reads drain in order.
- RMW_EN: addr 7 = 0x11223344, write 0xAABBCCDD mask 0b0101 -> read back 0x11BB33DD; req_ready low exactly one cycle; mask 0 -> CSB stays 1.
- Without RMW_EN: same write -> readback 0xAABBCCDD.
- Assert reset_n low cycle after read accept -> no resp_valid after release; pins idle during reset; first post-reset read returns correct data.

Source files
------------

// File: rtl/sram1rw_req_ctrl.sv
// Valid/ready request front-end for a single-port SRAM1RW macro with a 3-entry read response FIFO.
// Define SRAM1RW_REQ_CTRL_RMW_EN to honour byte write masks through a read-modify-write sequence.
module sram1rw_req_ctrl #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32,
    localparam int MASK_W = DATA_W / 8
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [MASK_W-1:0] req_wmask,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic [ADDR_W-1:0] sram_A,
    output logic              sram_CSB,
    output logic              sram_WEB,
    output logic              sram_OEB,
    output logic [DATA_W-1:0] sram_I,
    input  logic [DATA_W-1:0] sram_O
);

    logic [1:0]        r_count;
    logic [1:0]        r_rd_ptr;
    logic [1:0]        r_wr_ptr;
    logic              r_inflight;
    logic [DATA_W-1:0] r_buf [3];

    logic [2:0]        w_outstanding;
    logic              w_credit_ok;
    logic              w_idle;
    logic              w_accept;
    logic              w_rd_issue;
    logic              w_wr_full;
    logic              w_rmw_start;
    logic              w_merge_cycle;
    logic [ADDR_W-1:0] w_merge_addr;
    logic [DATA_W-1:0] w_merge_data;
    logic              w_push;
    logic              w_pop;

    // Credit ignores a same-cycle pop, so the FIFO can never overflow.
    assign w_outstanding = {2'b00, r_inflight} + {1'b0, r_count};
    assign w_credit_ok   = (w_outstanding < 3'd3);
    assign req_ready     = reset_n && w_idle && !(req_valid && !req_write && !w_credit_ok);
    assign w_accept      = req_valid && req_ready;
    assign w_rd_issue    = w_accept && !req_write;

`ifdef SRAM1RW_REQ_CTRL_RMW_EN
    typedef enum logic {S_IDLE, S_RMW_MERGE} state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [MASK_W-1:0] r_mask;

    assign w_idle        = (r_state == S_IDLE);
    assign w_wr_full     = w_accept && req_write && (&req_wmask);
    assign w_rmw_start   = w_accept && req_write && !(&req_wmask) && (|req_wmask);
    assign w_merge_cycle = (r_state == S_RMW_MERGE);
    assign w_merge_addr  = r_addr;

    always_comb begin
        w_merge_data = sram_O;
        for (int unsigned b = 0; b < MASK_W; b++) begin
            if (r_mask[b]) w_merge_data[b*8 +: 8] = r_wdata[b*8 +: 8];
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_addr  <= '0;
            r_wdata <= '0;
            r_mask  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_rmw_start) begin
                        r_state <= S_RMW_MERGE;
                        r_addr  <= req_addr;
                        r_wdata <= req_wdata;
                        r_mask  <= req_wmask;
                    end
                end
                S_RMW_MERGE: r_state <= S_IDLE;
                default:     r_state <= S_IDLE;
            endcase
        end
    end
`else
    logic w_unused_wmask;

    assign w_unused_wmask = ^req_wmask;
    assign w_idle         = 1'b1;
    assign w_wr_full      = w_accept && req_write;
    assign w_rmw_start    = 1'b0;
    assign w_merge_cycle  = 1'b0;
    assign w_merge_addr   = '0;
    assign w_merge_data   = '0;
`endif

    // The RMW read uses the read pin pattern but never sets the in-flight flag.
    always_comb begin
        sram_CSB = 1'b1;
        sram_WEB = 1'b1;
        sram_OEB = 1'b1;
        sram_A   = '0;
        sram_I   = '0;
        if (w_merge_cycle) begin
            sram_CSB = 1'b0;
            sram_WEB = 1'b0;
            sram_A   = w_merge_addr;
            sram_I   = w_merge_data;
        end else if (w_rd_issue || w_rmw_start) begin
            sram_CSB = 1'b0;
            sram_OEB = 1'b0;
            sram_A   = req_addr;
        end else if (w_wr_full) begin
            sram_CSB = 1'b0;
            sram_WEB = 1'b0;
            sram_A   = req_addr;
            sram_I   = req_wdata;
        end
    end

    assign resp_valid = (r_count != 2'd0);
    assign resp_rdata = r_buf[r_rd_ptr];
    assign w_push     = r_inflight;
    assign w_pop      = resp_valid && resp_ready;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_inflight <= 1'b0;
            r_count    <= '0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            for (int unsigned i = 0; i < 3; i++) r_buf[i] <= '0;
        end else begin
            r_inflight <= w_rd_issue;
            if (w_push) begin
                r_buf[r_wr_ptr] <= sram_O;
                r_wr_ptr        <= (r_wr_ptr == 2'd2) ? 2'd0 : r_wr_ptr + 2'd1;
            end
            if (w_pop) r_rd_ptr <= (r_rd_ptr == 2'd2) ? 2'd0 : r_rd_ptr + 2'd1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_sram1rw_req_ctrl.sv
// Self-checking bench for sram1rw_req_ctrl with a behavioural SRAM macro and a shadow-memory reference model.
`timescale 1ns/1ps
module tb_sram1rw_req_ctrl;
    localparam int AW = 9;
    localparam int DW = 32;
    localparam int MW = DW / 8;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          req_valid, req_ready, req_write;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic [MW-1:0] req_wmask;
    logic          resp_valid, resp_ready;
    logic [DW-1:0] resp_rdata;
    logic [AW-1:0] sram_A;
    logic          sram_CSB, sram_WEB, sram_OEB;
    logic [DW-1:0] sram_I, sram_O;

    always #5 clock = ~clock;

    sram1rw_req_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clock(clock), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
        .sram_A(sram_A), .sram_CSB(sram_CSB), .sram_WEB(sram_WEB), .sram_OEB(sram_OEB),
        .sram_I(sram_I), .sram_O(sram_O)
    );

    // Macro model: pins sampled at the clock edge, read data registered.
    logic [DW-1:0] smem [0:(1<<AW)-1];
    always @(posedge clock) begin
        if (!sram_CSB && !sram_WEB) smem[sram_A] <= sram_I;
        if (!sram_CSB && !sram_OEB) sram_O <= smem[sram_A];
    end

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // Reference: memory contents as seen by the request stream, plus expected responses in order.
    logic [DW-1:0] mem_m [0:(1<<AW)-1];
    logic [DW-1:0] expq[$];
    int            expc[$];
    bit            busy;

    function automatic logic [DW-1:0] apply_w(input logic [DW-1:0] old_d, input logic [DW-1:0] new_d,
                                              input logic [MW-1:0] m);
        logic [DW-1:0] r;
        r = old_d;
`ifdef SRAM1RW_REQ_CTRL_RMW_EN
        for (int i = 0; i < MW; i++) if (m[i]) r[i*8 +: 8] = new_d[i*8 +: 8];
`else
        r = (m == m) ? new_d : new_d;
`endif
        return r;
    endfunction

    function automatic bit is_partial(input logic [MW-1:0] m);
`ifdef SRAM1RW_REQ_CTRL_RMW_EN
        return (m != '1) && (m != '0);
`else
        return (m != m);
`endif
    endfunction

    task automatic model_accept(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                                input logic [MW-1:0] m);
        if (w) mem_m[a] = apply_w(mem_m[a], d, m);
        else begin
            expq.push_back(mem_m[a]);
            expc.push_back(cyc);
        end
    endtask

    task automatic drive(input logic v, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic [MW-1:0] m, input logic rr);
        req_valid = v; req_write = w; req_addr = a; req_wdata = d; req_wmask = m; resp_ready = rr;
        #1;
    endtask

    task automatic test_reset();
        drive(1'b1, 1'b0, 9'h1A5, 32'h0, 4'h0, 1'b1);
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL rst_req_ready: got %b want 0", req_ready); end
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL rst_resp_valid: got %b want 0", resp_valid); end
        checks++; if (resp_rdata !== 32'h0) begin errors++; $display("FAIL rst_resp_rdata: got %h want 0", resp_rdata); end
        checks++; if ({sram_CSB, sram_WEB, sram_OEB} !== 3'b111) begin
            errors++; $display("FAIL rst_ctl_pins: got %b want 111", {sram_CSB, sram_WEB, sram_OEB}); end
        checks++; if (sram_A !== '0 || sram_I !== '0) begin
            errors++; $display("FAIL rst_data_pins: A=%h I=%h want 0/0", sram_A, sram_I); end
        @(negedge clock); @(negedge clock);
        reset_n = 1'b1;
        drive(1'b0, 1'b0, '0, '0, '0, 1'b1);
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL post_rst_ready: got %b want 1", req_ready); end
    endtask

    task automatic test_write_read();
        @(negedge clock); drive(1'b1, 1'b1, 9'd5, 32'hDEADBEEF, 4'hF, 1'b1);
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL wr_ready: got %b want 1", req_ready); end
        checks++; if ({sram_CSB, sram_WEB, sram_OEB} !== 3'b001 || sram_A !== 9'd5 || sram_I !== 32'hDEADBEEF) begin
            errors++; $display("FAIL wr_pins: csb/web/oeb=%b A=%h I=%h want 001/005/deadbeef",
                               {sram_CSB, sram_WEB, sram_OEB}, sram_A, sram_I); end
        model_accept(1'b1, 9'd5, 32'hDEADBEEF, 4'hF);
        @(negedge clock); drive(1'b1, 1'b0, 9'd5, '0, '0, 1'b1);
        checks++; if (req_ready !== 1'b1 || {sram_CSB, sram_WEB, sram_OEB} !== 3'b010 || sram_A !== 9'd5) begin
            errors++; $display("FAIL rd_pins: ready=%b csb/web/oeb=%b A=%h want 1/010/005",
                               req_ready, {sram_CSB, sram_WEB, sram_OEB}, sram_A); end
        model_accept(1'b0, 9'd5, '0, '0);
        @(negedge clock); drive(1'b0, 1'b0, '0, '0, '0, 1'b1);
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL rd_lat_n1: resp_valid=%b want 0", resp_valid); end
        @(negedge clock); drive(1'b0, 1'b0, '0, '0, '0, 1'b1);
        checks++; if (resp_valid !== 1'b1 || resp_rdata !== 32'hDEADBEEF) begin
            errors++; $display("FAIL rd_lat_n2: valid=%b rdata=%h want 1/deadbeef", resp_valid, resp_rdata); end
        expq.pop_front(); expc.pop_front();
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] d;
        for (int i = 0; i < 16; i++) begin
            d = $urandom;
            @(negedge clock); drive(1'b1, 1'b1, AW'(i), d, 4'hF, 1'b1);
            checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL b2b_wr_ready[%0d]: got %b want 1", i, req_ready); end
            if (req_ready) model_accept(1'b1, AW'(i), d, 4'hF);
        end
        for (int c = 0; c < 20; c++) begin
            @(negedge clock);
            if (c < 16) drive(1'b1, 1'b0, AW'(c), '0, '0, 1'b1);
            else drive(1'b0, 1'b0, '0, '0, '0, 1'b1);
            if (c < 16) begin
                checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL b2b_rd_ready[%0d]: got %b want 1", c, req_ready); end
            end
            checks++; if (resp_valid !== (c >= 2 && c < 18)) begin
                errors++; $display("FAIL b2b_valid[%0d]: got %b want %b", c, resp_valid, (c >= 2 && c < 18)); end
            if (resp_valid && expq.size() > 0) begin
                checks++; if (resp_rdata !== expq[0]) begin
                    errors++; $display("FAIL b2b_rdata[%0d]: got %h want %h", c, resp_rdata, expq[0]); end
                expq.pop_front(); expc.pop_front();
            end
            if (req_valid && req_ready) model_accept(1'b0, req_addr, '0, '0);
        end
    endtask

    task automatic test_credit();
        int k = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clock); drive(1'b1, 1'b0, AW'(k), '0, '0, 1'b0);
            if (req_ready) begin model_accept(1'b0, AW'(k), '0, '0); k++; end
        end
        checks++; if (k !== 3) begin errors++; $display("FAIL credit_accepts: got %0d want 3", k); end
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL credit_ready: got %b want 0", req_ready); end
        checks++; if (resp_valid !== 1'b1 || resp_rdata !== expq[0]) begin
            errors++; $display("FAIL credit_hold: valid=%b rdata=%h want 1/%h", resp_valid, resp_rdata, expq[0]); end
        @(negedge clock); drive(1'b1, 1'b1, 9'd20, 32'h5A5A0F0F, 4'hF, 1'b0);
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL credit_write: ready=%b want 1", req_ready); end
        if (req_ready) model_accept(1'b1, 9'd20, 32'h5A5A0F0F, 4'hF);
        for (int c = 0; c < 30 && !(k == 5 && expq.size() == 0); c++) begin
            @(negedge clock); drive(k < 5, 1'b0, AW'(k), '0, '0, 1'b1);
            if (resp_valid) begin
                checks++; if (expq.size() == 0 || resp_rdata !== expq[0]) begin
                    errors++; $display("FAIL credit_drain: rdata=%h want %h", resp_rdata, (expq.size() > 0) ? expq[0] : 'x); end
                if (expq.size() > 0) begin expq.pop_front(); expc.pop_front(); end
            end
            if (req_valid && req_ready) begin model_accept(1'b0, AW'(k), '0, '0); k++; end
        end
        checks++; if (k != 5 || expq.size() != 0) begin
            errors++; $display("FAIL credit_timeout: accepted=%0d pending=%0d want 5/0", k, expq.size());
            expq.delete(); expc.delete(); end
    endtask

    task automatic test_mask();
        @(negedge clock); drive(1'b1, 1'b1, 9'd7, 32'h11223344, 4'hF, 1'b0);
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL mask_base_ready: got %b want 1", req_ready); end
        model_accept(1'b1, 9'd7, 32'h11223344, 4'hF);
        @(negedge clock); drive(1'b1, 1'b1, 9'd7, 32'hAABBCCDD, 4'b0101, 1'b0);
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL mask_part_ready: got %b want 1", req_ready); end
        model_accept(1'b1, 9'd7, 32'hAABBCCDD, 4'b0101);
`ifdef SRAM1RW_REQ_CTRL_RMW_EN
        checks++; if ({sram_CSB, sram_WEB, sram_OEB} !== 3'b010 || sram_A !== 9'd7) begin
            errors++; $display("FAIL rmw_read_pins: csb/web/oeb=%b A=%h want 010/007", {sram_CSB, sram_WEB, sram_OEB}, sram_A); end
        @(negedge clock); drive(1'b1, 1'b0, 9'd7, '0, '0, 1'b0);
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL rmw_busy: ready=%b want 0", req_ready); end
        checks++; if ({sram_CSB, sram_WEB} !== 2'b00 || sram_A !== 9'd7 || sram_I !== 32'h11BB33DD) begin
            errors++; $display("FAIL rmw_merge_pins: csb/web=%b A=%h I=%h want 00/007/11bb33dd",
                               {sram_CSB, sram_WEB}, sram_A, sram_I); end
        @(negedge clock); drive(1'b1, 1'b0, 9'd7, '0, '0, 1'b0);
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rmw_release: ready=%b want 1", req_ready); end
        model_accept(1'b0, 9'd7, '0, '0);
        @(negedge clock); drive(1'b1, 1'b1, 9'd7, 32'h0, 4'h0, 1'b0);
        checks++; if (req_ready !== 1'b1 || sram_CSB !== 1'b1) begin
            errors++; $display("FAIL mask_zero: ready=%b csb=%b want 1/1", req_ready, sram_CSB); end
`else
        checks++; if ({sram_CSB, sram_WEB} !== 2'b00 || sram_I !== 32'hAABBCCDD) begin
            errors++; $display("FAIL nomask_pins: csb/web=%b I=%h want 00/aabbccdd", {sram_CSB, sram_WEB}, sram_I); end
        @(negedge clock); drive(1'b1, 1'b0, 9'd7, '0, '0, 1'b0);
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL nomask_rd_ready: ready=%b want 1", req_ready); end
        model_accept(1'b0, 9'd7, '0, '0);
        @(negedge clock); drive(1'b1, 1'b1, 9'd7, 32'h0, 4'h0, 1'b0);
        checks++; if (req_ready !== 1'b1 || sram_CSB !== 1'b0) begin
            errors++; $display("FAIL nomask_zero: ready=%b csb=%b want 1/0", req_ready, sram_CSB); end
`endif
        model_accept(1'b1, 9'd7, 32'h0, 4'h0);
        @(negedge clock); drive(1'b1, 1'b0, 9'd7, '0, '0, 1'b0);
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL mask_rd2_ready: ready=%b want 1", req_ready); end
        model_accept(1'b0, 9'd7, '0, '0);
        for (int c = 0; c < 12 && expq.size() > 0; c++) begin
            @(negedge clock); drive(1'b0, 1'b0, '0, '0, '0, 1'b1);
            if (resp_valid) begin
                checks++; if (resp_rdata !== expq[0]) begin
                    errors++; $display("FAIL mask_rdata: got %h want %h", resp_rdata, expq[0]); end
                expq.pop_front(); expc.pop_front();
            end
        end
        checks++; if (expq.size() != 0) begin
            errors++; $display("FAIL mask_timeout: %0d responses missing, want 0", expq.size()); expq.delete(); expc.delete(); end
    endtask

    task automatic test_reset_midflight();
        @(negedge clock); drive(1'b1, 1'b0, 9'd3, '0, '0, 1'b1);
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL mid_rd_ready: got %b want 1", req_ready); end
        @(negedge clock); reset_n = 1'b0; drive(1'b1, 1'b0, 9'd4, '0, '0, 1'b1);
        expq.delete(); expc.delete();
        checks++; if (req_ready !== 1'b0 || resp_valid !== 1'b0) begin
            errors++; $display("FAIL mid_rst_hs: ready=%b valid=%b want 0/0", req_ready, resp_valid); end
        checks++; if ({sram_CSB, sram_WEB, sram_OEB} !== 3'b111 || sram_A !== '0) begin
            errors++; $display("FAIL mid_rst_pins: csb/web/oeb=%b A=%h want 111/000", {sram_CSB, sram_WEB, sram_OEB}, sram_A); end
        @(negedge clock); drive(1'b1, 1'b0, 9'd4, '0, '0, 1'b1);
        @(negedge clock); reset_n = 1'b1; drive(1'b0, 1'b0, '0, '0, '0, 1'b1);
        for (int c = 0; c < 4; c++) begin
            @(negedge clock); drive(1'b0, 1'b0, '0, '0, '0, 1'b1);
            checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL mid_no_resp[%0d]: valid=%b want 0", c, resp_valid); end
        end
        @(negedge clock); drive(1'b1, 1'b0, 9'd3, '0, '0, 1'b1);
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL mid_post_ready: got %b want 1", req_ready); end
        model_accept(1'b0, 9'd3, '0, '0);
        for (int c = 0; c < 12 && expq.size() > 0; c++) begin
            @(negedge clock); drive(1'b0, 1'b0, '0, '0, '0, 1'b1);
            if (resp_valid) begin
                checks++; if (resp_rdata !== expq[0]) begin
                    errors++; $display("FAIL mid_rdata: got %h want %h", resp_rdata, expq[0]); end
                expq.pop_front(); expc.pop_front();
            end
        end
        checks++; if (expq.size() != 0) begin
            errors++; $display("FAIL mid_timeout: %0d responses missing, want 0", expq.size()); expq.delete(); expc.delete(); end
    endtask

    task automatic test_random();
        logic v, w, rr, exp_ready, exp_valid;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [MW-1:0] m;
        int sel;
        busy = 1'b0;
        for (int c = 0; c < 300; c++) begin
            v = ($urandom_range(0, 3) != 0);
            w = ($urandom_range(0, 2) == 0);
            a = AW'($urandom_range(0, 15));
            d = $urandom;
            sel = $urandom_range(0, 2);
            m = (sel == 0) ? 4'hF : (sel == 1) ? 4'h0 : MW'($urandom_range(0, 15));
            rr = ($urandom_range(0, 3) != 0);
            @(negedge clock); drive(v, w, a, d, m, rr);
            exp_ready = !busy && !(v && !w && expq.size() >= 3);
            checks++; if (req_ready !== exp_ready) begin
                errors++; $display("FAIL rnd_ready[%0d]: got %b want %b", c, req_ready, exp_ready); end
            exp_valid = (expq.size() > 0) && (expc[0] + 2 <= cyc);
            checks++; if (resp_valid !== exp_valid) begin
                errors++; $display("FAIL rnd_valid[%0d]: got %b want %b", c, resp_valid, exp_valid); end
            if (resp_valid && exp_valid) begin
                checks++; if (resp_rdata !== expq[0]) begin
                    errors++; $display("FAIL rnd_rdata[%0d]: got %h want %h", c, resp_rdata, expq[0]); end
            end
            if (resp_valid && rr && expq.size() > 0) begin expq.pop_front(); expc.pop_front(); end
            busy = 1'b0;
            if (v && req_ready) begin
                busy = w && is_partial(m);
                model_accept(w, a, d, m);
            end
        end
        for (int c = 0; c < 16 && expq.size() > 0; c++) begin
            @(negedge clock); drive(1'b0, 1'b0, '0, '0, '0, 1'b1);
            if (resp_valid) begin
                checks++; if (resp_rdata !== expq[0]) begin
                    errors++; $display("FAIL rnd_drain: got %h want %h", resp_rdata, expq[0]); end
                expq.pop_front(); expc.pop_front();
            end
        end
        checks++; if (expq.size() != 0) begin
            errors++; $display("FAIL rnd_timeout: %0d responses missing, want 0", expq.size()); expq.delete(); expc.delete(); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_back_to_back();
        test_credit();
        test_mask();
        test_reset_midflight();
        test_random();
        @(negedge clock);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
